trace_capture: RTL and testbench

Synthesizable execution-trace buffer for the soft MPU. It records retired-instruction snapshots (PC, instruction, accumulator) into a parametrised circular buffer. Capture is arranged around a PC-match trigger, and the block then replays the window oldest-first over a valid/ready port. It sits beside the top-level datapath/controller pair, tapping their retire strobe, so on-chip debug gets the visibility that simulation-only signal probing provides.

---
 rtl/trace_pkg.sv | 43 ++++
 rtl/trace_ram.sv | 42 ++++
 rtl/trace_capture.sv | 213 +++++++++++++++++++++
 tb/tb_trace_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the execution-trace capture block: state encoding,
// entry-width helpers and the pointer/count width function.
// Build option: TRACE_TIMESTAMP_EN adds a timestamp field to every entry.
package trace_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_POST  = 3'd2,
      ST_FETCH = 3'd3,
      ST_READ  = 3'd4
   } state_e;

`ifdef TRACE_TIMESTAMP_EN
   localparam bit TRACE_TS_ON = 1'b1;
`else
   localparam bit TRACE_TS_ON = 1'b0;
`endif

   // Bits needed to encode the values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 32'sd0;
      span   = 32'sd1;
      while (span < value) begin
         span   = span * 32'sd2;
         result = result + 32'sd1;
      end
      return result;
   endfunction

   // Width of one stored trace entry: {pc, instr, acc[, ts]}.
   function automatic int entry_width(input int pc_w, input int data_w, input int ts_w);
      return pc_w + (32'sd2 * data_w) + ts_w;
   endfunction

   // Timestamp field width actually stored, zero when the option is off.
   function automatic int ts_field_width(input int ts_w);
      return TRACE_TS_ON ? ts_w : 32'sd0;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port
// with a single cycle of latency. The read register holds its value until the
// next read is issued, so the readout stays stable while the consumer stalls.
module trace_ram
   import trace_pkg::*;
#(
   parameter int WIDTH = 22,
   parameter int DEPTH = 16,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // Storage array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; cleared on reset so the readout bus starts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/trace_capture.sv
// Execution-trace buffer: records retire snapshots into a circular buffer,
// arranges the window around a PC-match trigger and replays it oldest-first
// over a valid/ready port.
// Build option: TRACE_TIMESTAMP_EN stores a free-running timestamp with each
// entry and adds the rd_ts port.
module trace_capture
   import trace_pkg::*;
#(
   parameter int PC_W   = 6,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int POST   = 8,
   parameter int TS_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        arm,
   input  logic                        trig_en,
   input  logic [PC_W-1:0]             trig_pc,
   input  logic                        st_valid,
   input  logic [PC_W-1:0]             st_pc,
   input  logic [DATA_W-1:0]           st_instr,
   input  logic [DATA_W-1:0]           st_acc,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [PC_W-1:0]             rd_pc,
   output logic [DATA_W-1:0]           rd_instr,
   output logic [DATA_W-1:0]           rd_acc,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]             rd_ts,
`endif
   output logic                        busy,
   output logic                        done,
   output logic [clog2(DEPTH+1)-1:0]   count
);

   localparam int AW         = clog2(DEPTH);
   localparam int CNT_W      = clog2(DEPTH + 1);
   localparam int TS_FIELD_W = ts_field_width(TS_W);
   localparam int ENTRY_W    = entry_width(PC_W, DATA_W, TS_FIELD_W);

   localparam logic [AW-1:0]    PTR_ONE  = AW'(32'd1);
   localparam logic [AW-1:0]    POST_V   = AW'(POST);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   state_e             state_r, state_s;
   logic [AW-1:0]      wptr_r, wptr_s;
   logic [AW-1:0]      rptr_r, rptr_s;
   logic [CNT_W-1:0]   count_r, count_s;
   logic [AW-1:0]      post_cnt_r, post_cnt_s;
   logic               busy_r, done_r, rd_valid_r;

   logic               wr_en_s;
   logic               re_s;
   logic               trig_s;
   logic [AW-1:0]      wptr_inc_s;
   logic [CNT_W-1:0]   count_inc_s;
   logic [AW-1:0]      start_ptr_s;
   logic [ENTRY_W-1:0] wdata_s;
   logic [ENTRY_W-1:0] rdata_s;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]    ts_r;

   // Free-running timestamp, wraps naturally at 2^TS_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_r <= '0;
      end else begin
         ts_r <= ts_r + TS_W'(32'd1);
      end
   end

   assign wdata_s = {st_pc, st_instr, st_acc, ts_r};
   assign rd_ts   = rdata_s[TS_W-1:0];
`else
   assign wdata_s = {st_pc, st_instr, st_acc};
`endif

   // A retire that meets the trigger condition; only acted on while ARMED.
   assign trig_s = st_valid && (!trig_en || (st_pc == trig_pc));

   // Pointer/count values after a capture write, and the oldest entry they imply.
   assign wptr_inc_s  = wptr_r + PTR_ONE;
   assign count_inc_s = (count_r == CNT_FULL) ? count_r : (count_r + CNT_ONE);
   assign start_ptr_s = wptr_inc_s - count_inc_s[AW-1:0];

   // Next-state and datapath control for capture and readout.
   always_comb begin
      state_s    = state_r;
      wptr_s     = wptr_r;
      rptr_s     = rptr_r;
      count_s    = count_r;
      post_cnt_s = post_cnt_r;
      wr_en_s    = 1'b0;
      re_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arm) begin
               state_s = ST_ARMED;
               wptr_s  = '0;
               count_s = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (st_valid) begin
               wr_en_s = 1'b1;
               wptr_s  = wptr_inc_s;
               count_s = count_inc_s;
               if (trig_s) begin
                  post_cnt_s = POST_V;
                  if (POST == 0) begin
                     state_s = ST_FETCH;
                     rptr_s  = start_ptr_s;
                  end else begin
                     state_s = ST_POST;
                  end
               end else begin
                  state_s = ST_ARMED;
               end
            end else begin
               state_s = ST_ARMED;
            end
         end
         ST_POST: begin
            if (st_valid) begin
               wr_en_s    = 1'b1;
               wptr_s     = wptr_inc_s;
               count_s    = count_inc_s;
               post_cnt_s = post_cnt_r - PTR_ONE;
               if (post_cnt_r == PTR_ONE) begin
                  state_s = ST_FETCH;
                  rptr_s  = start_ptr_s;
               end else begin
                  state_s = ST_POST;
               end
            end else begin
               state_s = ST_POST;
            end
         end
         ST_FETCH: begin
            re_s    = 1'b1;
            state_s = ST_READ;
         end
         ST_READ: begin
            if (rd_ready) begin
               rptr_s  = rptr_r + PTR_ONE;
               count_s = count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_FETCH;
               end
            end else begin
               state_s = ST_READ;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, pointers and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         wptr_r     <= '0;
         rptr_r     <= '0;
         count_r    <= '0;
         post_cnt_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rd_valid_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         wptr_r     <= wptr_s;
         rptr_r     <= rptr_s;
         count_r    <= count_s;
         post_cnt_r <= post_cnt_s;
         busy_r     <= (state_s == ST_ARMED) || (state_s == ST_POST);
         done_r     <= (state_s == ST_FETCH) || (state_s == ST_READ);
         rd_valid_r <= (state_s == ST_READ);
      end
   end

   trace_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en_s),
      .waddr (wptr_r),
      .wdata (wdata_s),
      .re    (re_s),
      .raddr (rptr_r),
      .rdata (rdata_s)
   );

   assign rd_pc    = rdata_s[ENTRY_W-1 -: PC_W];
   assign rd_instr = rdata_s[ENTRY_W-PC_W-1 -: DATA_W];
   assign rd_acc   = rdata_s[TS_FIELD_W +: DATA_W];
   assign rd_valid = rd_valid_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign count    = count_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DEPTH=16, POST=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_trace_capture;

   localparam int PC_W   = 6;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int POST   = 8;
   localparam int TS_W   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              arm;
   logic              trig_en;
   logic [PC_W-1:0]   trig_pc;
   logic              st_valid;
   logic [PC_W-1:0]   st_pc;
   logic [DATA_W-1:0] st_instr;
   logic [DATA_W-1:0] st_acc;
   logic              rd_valid;
   logic              rd_ready;
   logic [PC_W-1:0]   rd_pc;
   logic [DATA_W-1:0] rd_instr;
   logic [DATA_W-1:0] rd_acc;
   logic              busy;
   logic              done;
   logic [4:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] rd_ts;
   logic [TS_W-1:0] tb_ts;
   logic [TS_W-1:0] pop_ts;

   // Reference timestamp: cleared by rst, +1 every cycle.
   always @(posedge clk) begin
      if (rst) tb_ts <= 16'd0;
      else     tb_ts <= tb_ts + 16'd1;
   end
`endif

   trace_capture #(
      .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST(POST), .TS_W(TS_W)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_acc(st_acc),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_acc(rd_acc),
`ifdef TRACE_TIMESTAMP_EN
      .rd_ts(rd_ts),
`endif
      .busy(busy), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_instr(input logic [5:0] pc);
      return 8'hA5 ^ {2'b00, pc};
   endfunction

   function automatic logic [7:0] exp_acc(input logic [5:0] pc);
      return {2'b00, pc} + 8'h31;
   endfunction

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = 6'd0;
      st_valid = 1'b0; st_pc = 6'd0; st_instr = 8'd0; st_acc = 8'd0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_arm(input logic te, input logic [5:0] tp);
      trig_en = te; trig_pc = tp; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic feed(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         st_valid = 1'b1;
         st_pc    = 6'(first + i);
         st_instr = exp_instr(6'(first + i));
         st_acc   = exp_acc(6'(first + i));
         @(negedge clk);
      end
      st_valid = 1'b0;
   endtask

   // Waits (bounded) for rd_valid, takes the entry, then handshakes it.
   task automatic pop_entry(output logic [5:0] pc, output logic [7:0] instr,
                            output logic [7:0] acc, output bit ok);
      pc = 6'd0; instr = 8'd0; acc = 8'd0; ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (rd_valid === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         pc = rd_pc; instr = rd_instr; acc = rd_acc;
`ifdef TRACE_TIMESTAMP_EN
         pop_ts = rd_ts;
`endif
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({rd_valid, busy, done, count} !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_status: got valid=%b busy=%b done=%b count=%0d, expected all 0",
                  rd_valid, busy, done, count);
      end
      n_checks++;
      if ({rd_pc, rd_instr, rd_acc} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_rd_data: got %h/%h/%h, expected 0/0/0", rd_pc, rd_instr, rd_acc);
      end
      rd_ready = 1'b1;
      feed(1, 3);
      rd_ready = 1'b0;
      n_checks++;
      if ({busy, count, rd_valid} !== 7'd0) begin
         n_fail++;
         $display("FAIL idle_ignores_retire: got busy=%b count=%0d valid=%b, expected 0/0/0",
                  busy, count, rd_valid);
      end
   endtask

   // Pops n entries expecting consecutive pcs from first_pc, then an idle block.
   task automatic drain_and_check(input string name, input int first_pc, input int n);
      logic [5:0] pc;
      logic [7:0] ins, acc;
      bit ok;
      logic [5:0] epc;
      for (int k = 0; k < n; k++) begin
         pop_entry(pc, ins, acc, ok);
         epc = 6'(first_pc + k);
         n_checks++;
         if (!ok || {pc, ins, acc} !== {epc, exp_instr(epc), exp_acc(epc)}) begin
            n_fail++;
            $display("FAIL %s_entry%0d: got ok=%b pc=%0d instr=%h acc=%h, expected pc=%0d instr=%h acc=%h",
                     name, k, ok, pc, ins, acc, epc, exp_instr(epc), exp_acc(epc));
         end
      end
      n_checks++;
      if ({busy, done, count, rd_valid} !== 8'd0) begin
         n_fail++;
         $display("FAIL %s_idle_after: got busy=%b done=%b count=%0d valid=%b, expected 0/0/0/0",
                  name, busy, done, count, rd_valid);
      end
   endtask

   task automatic test_pc_match_wrap();
      do_arm(1'b1, 6'd20);
      n_checks++;
      if ({busy, done, count} !== {1'b1, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL armed_status: got busy=%b done=%b count=%0d, expected 1/0/0", busy, done, count);
      end
      feed(0, 41);
      n_checks++;
      if ({count, done, busy, rd_valid} !== {5'd16, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_capture: got count=%0d done=%b busy=%b valid=%b, expected 16/1/0/1",
                  count, done, busy, rd_valid);
      end
      drain_and_check("wrap", 13, 16);
   endtask

   task automatic test_hold_and_arm();
      do_arm(1'b1, 6'd3);
      feed(0, 20);
      n_checks++;
      if (count !== 5'd12) begin
         n_fail++;
         $display("FAIL early_trig_count: got %0d, expected 12", count);
      end
      for (int i = 0; i < 5; i++) begin
         arm = (i == 2) ? 1'b1 : 1'b0;
         @(negedge clk);
         n_checks++;
         if ({rd_valid, done, rd_pc, rd_instr, rd_acc, count} !==
             {1'b1, 1'b1, 6'd0, exp_instr(6'd0), exp_acc(6'd0), 5'd12}) begin
            n_fail++;
            $display("FAIL hold_stable%0d: got valid=%b done=%b pc=%0d instr=%h acc=%h count=%0d, expected 1/1/0/%h/%h/12",
                     i, rd_valid, done, rd_pc, rd_instr, rd_acc, count, exp_instr(6'd0), exp_acc(6'd0));
         end
      end
      arm = 1'b0;
      drain_and_check("early", 0, 12);
   endtask

   task automatic test_first_retire();
      do_arm(1'b0, 6'd63);
      feed(5, 16);
      n_checks++;
      if (count !== 5'd9) begin
         n_fail++;
         $display("FAIL first_retire_count: got %0d, expected 9", count);
      end
      drain_and_check("first", 5, 9);
   endtask

   task automatic test_reset_mid_post();
      do_arm(1'b1, 6'd2);
      feed(0, 5);
      n_checks++;
      if ({busy, count} !== {1'b1, 5'd5}) begin
         n_fail++;
         $display("FAIL mid_post_status: got busy=%b count=%0d, expected 1/5", busy, count);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({rd_valid, busy, done, count, rd_pc, rd_instr, rd_acc} !== 30'd0) begin
         n_fail++;
         $display("FAIL mid_post_reset: got valid=%b busy=%b done=%b count=%0d data=%h/%h/%h, expected all 0",
                  rd_valid, busy, done, count, rd_pc, rd_instr, rd_acc);
      end
      do_arm(1'b0, 6'd0);
      feed(30, 12);
      n_checks++;
      if (count !== 5'd9) begin
         n_fail++;
         $display("FAIL recapture_count: got %0d, expected 9", count);
      end
      drain_and_check("recapture", 30, 9);
   endtask

`ifdef TRACE_TIMESTAMP_EN
   task automatic test_timestamp();
      logic [5:0] pc;
      logic [7:0] ins, acc;
      bit ok;
      do_reset();
      do_arm(1'b1, 6'd2);
      for (int i = 0; i < 300 && tb_ts != 16'd100; i++) @(negedge clk);
      feed(1, 1);
      repeat (2) @(negedge clk);
      feed(2, 9);
      n_checks++;
      if (count !== 5'd10) begin
         n_fail++;
         $display("FAIL ts_count: got %0d, expected 10", count);
      end
      pop_entry(pc, ins, acc, ok);
      n_checks++;
      if (!ok || {pc, pop_ts} !== {6'd1, 16'd100}) begin
         n_fail++;
         $display("FAIL ts_entry0: got pc=%0d ts=%0d, expected pc=1 ts=100", pc, pop_ts);
      end
      pop_entry(pc, ins, acc, ok);
      n_checks++;
      if (!ok || {pc, pop_ts} !== {6'd2, 16'd103}) begin
         n_fail++;
         $display("FAIL ts_entry1: got pc=%0d ts=%0d, expected pc=2 ts=103", pc, pop_ts);
      end
      pop_entry(pc, ins, acc, ok);
      n_checks++;
      if (!ok || {pc, pop_ts} !== {6'd3, 16'd104}) begin
         n_fail++;
         $display("FAIL ts_entry2: got pc=%0d ts=%0d, expected pc=3 ts=104", pc, pop_ts);
      end
      drain_and_check("ts", 4, 7);
   endtask
`endif

   initial begin
      rst = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = 6'd0; rd_ready = 1'b0;
      st_valid = 1'b0; st_pc = 6'd0; st_instr = 8'd0; st_acc = 8'd0;
      @(negedge clk);
      test_reset();
      test_pc_match_wrap();
      test_hold_and_arm();
      test_first_retire();
      test_reset_mid_post();
`ifdef TRACE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
